// File: rtl/riscv_pkg.sv
// Shared writeback types: register-file widths and the {wa, wd} request
// carried through the long-latency buffer and the selection mux.
package riscv_pkg;

    localparam int DATA_WIDTH    = 64;
    localparam int ADDRESS_WIDTH = 5;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] wa;
        logic [DATA_WIDTH-1:0]    wd;
    } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Writeback bus: ALU result port, long-latency valid/ready port, stall
// feedback and the register-file write port.
interface wb_arbiter_if;
    import riscv_pkg::*;

    logic                     alu_valid;
    logic [ADDRESS_WIDTH-1:0] alu_wa;
    logic [DATA_WIDTH-1:0]    alu_wd;
    logic                     lu_valid;
    logic                     lu_ready;
    logic [ADDRESS_WIDTH-1:0] lu_wa;
    logic [DATA_WIDTH-1:0]    lu_wd;
    logic                     stall_alu;
    logic                     RegWrite;
    logic [ADDRESS_WIDTH-1:0] wa;
    logic [DATA_WIDTH-1:0]    wd;

    // Pipeline side: offers results, observes back-pressure and the write port.
    modport master (
        output alu_valid, alu_wa, alu_wd, lu_valid, lu_wa, lu_wd,
        input  lu_ready, stall_alu, RegWrite, wa, wd
    );

    modport slave (
        input  alu_valid, alu_wa, alu_wd, lu_valid, lu_wa, lu_wd,
        output lu_ready, stall_alu, RegWrite, wa, wd
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests; pointers wrap modulo FIFO_DEPTH and
// the occupancy count tells full from empty, so any depth >= 1 works.
module wb_fifo
    import riscv_pkg::*;
#(
    parameter  int FIFO_DEPTH = 2,
    localparam int PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1,
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_push,
    input  wb_req_t          i_push_data,
    input  logic             i_pop,
    output wb_req_t          o_head,
    output logic [CNT_W-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);

    wb_req_t          r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; count and pointers
    // already mark every slot invalid, and a reset-free array maps to RAM.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win the register-file port, buffered
// long-latency results drain when the ALU is idle or a starvation stall fires.
module wb_arbiter
    import riscv_pkg::*;
#(
    parameter int FIFO_DEPTH   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic         clk,
    input logic         reset_n,
    wb_arbiter_if.slave bus
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int STV_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STV_W-1:0] STARVE_MAX = STV_W'(STARVE_LIMIT);

    wb_req_t          w_head;
    wb_req_t          w_alu_req;
    wb_req_t          w_lu_req;
    wb_req_t          w_sel;
    logic [CNT_W-1:0] w_count;
    logic             w_full;
    logic             w_empty;
    logic             w_lu_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_stall;
    logic             w_sel_alu;
    logic             w_sel_valid;

    logic [STV_W-1:0]         r_starve_cnt;
    logic                     r_reg_write;
    logic [ADDRESS_WIDTH-1:0] r_wa;
    logic [DATA_WIDTH-1:0]    r_wd;

    assign w_alu_req  = '{wa: bus.alu_wa, wd: bus.alu_wd};
    assign w_lu_req   = '{wa: bus.lu_wa,  wd: bus.lu_wd};
    assign w_lu_ready = reset_n && !w_full;
    // Results for x0 are accepted off the bus but never occupy a slot.
    assign w_push     = bus.lu_valid && w_lu_ready && (bus.lu_wa != '0);
    assign w_stall    = (r_starve_cnt == STARVE_MAX);

    wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_push      (w_push),
        .i_push_data (w_lu_req),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        w_sel_alu   = 1'b0;
        w_pop       = 1'b0;
        w_sel_valid = 1'b0;
        w_sel       = w_head;
        if (bus.alu_valid && !w_stall) begin
            w_sel_alu   = 1'b1;
            w_sel_valid = 1'b1;
            w_sel       = w_alu_req;
        end else if (!w_empty) begin
            w_pop       = 1'b1;
            w_sel_valid = 1'b1;
        end
    end

    // A stall only arises with the FIFO non-empty, so the stalled cycle always
    // pops and clears the counter, giving a one-cycle stall pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
        end else if (w_empty || w_pop) begin
            r_starve_cnt <= '0;
        end else if (w_sel_alu && !w_stall) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_reg_write <= 1'b0;
            r_wa        <= '0;
            r_wd        <= '0;
        end else begin
            r_reg_write <= w_sel_valid && (w_sel.wa != '0);
            if (w_sel_valid) begin
                r_wa <= w_sel.wa;
                r_wd <= w_sel.wd;
            end
        end
    end

    assign bus.lu_ready  = w_lu_ready;
    assign bus.stall_alu = reset_n && w_stall;
    assign bus.RegWrite  = r_reg_write;
    assign bus.wa        = r_wa;
    assign bus.wd        = r_wd;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, ALU path, x0, FIFO fill/order,
// starvation stall, simultaneous push/pop and reset mid-operation.
module tb_wb_arbiter;

    logic clk;
    logic reset_n;
    int   checks;
    int   failures;

    wb_arbiter_if bus ();

    wb_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance past one rising edge; inputs change and outputs are read at +1.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check_wr(input string tag, input logic we, input logic [4:0] a, input logic [63:0] d);
        check({tag, ".RegWrite"}, 64'(bus.RegWrite), 64'(we));
        if (we) begin
            check({tag, ".wa"}, 64'(bus.wa), 64'(a));
            check({tag, ".wd"}, bus.wd, d);
        end
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        reset_n       = 1'b0;
        bus.alu_valid = 1'b1;
        bus.alu_wa    = 5'd7;
        bus.alu_wd    = 64'h77;
        bus.lu_valid  = 1'b0;
        bus.lu_wa     = '0;
        bus.lu_wd     = '0;

        // Reset held three cycles with a live ALU result.
        step(); step(); step();
        check("rst.RegWrite", 64'(bus.RegWrite), 64'd0);
        check("rst.wa", 64'(bus.wa), 64'd0);
        check("rst.wd", bus.wd, 64'd0);
        check("rst.lu_ready", 64'(bus.lu_ready), 64'd0);
        check("rst.stall_alu", 64'(bus.stall_alu), 64'd0);

        reset_n       = 1'b1;
        bus.alu_valid = 1'b0;
        settle();
        check("rel.lu_ready", 64'(bus.lu_ready), 64'd1);

        // ALU path, then an ALU write to x0.
        bus.alu_valid = 1'b1; bus.alu_wa = 5'd5; bus.alu_wd = 64'hDEAD;
        step();
        check_wr("alu5", 1'b1, 5'd5, 64'hDEAD);
        bus.alu_wa = 5'd0; bus.alu_wd = 64'h1234;
        step();
        check("alu_x0.RegWrite", 64'(bus.RegWrite), 64'd0);

        // Fill the FIFO while the ALU keeps the port busy.
        bus.alu_wa = 5'd6; bus.alu_wd = 64'h66;
        bus.lu_valid = 1'b1; bus.lu_wa = 5'd3; bus.lu_wd = 64'h11;
        step();
        check_wr("fill.alu6", 1'b1, 5'd6, 64'h66);
        bus.alu_wa = 5'd7; bus.alu_wd = 64'h77;
        bus.lu_wa = 5'd4; bus.lu_wd = 64'h22;
        settle();
        check("fill.ready1", 64'(bus.lu_ready), 64'd1);
        step();
        check_wr("fill.alu7", 1'b1, 5'd7, 64'h77);
        bus.alu_wa = 5'd8; bus.alu_wd = 64'h88;
        bus.lu_wa = 5'd9; bus.lu_wd = 64'h99;
        settle();
        check("fill.ready_full", 64'(bus.lu_ready), 64'd0);
        step();
        check("fill.count", 64'(dut.w_count), 64'd2);
        bus.alu_valid = 1'b0; bus.lu_valid = 1'b0;
        step();
        check_wr("drain.r3", 1'b1, 5'd3, 64'h11);
        step();
        check_wr("drain.r4", 1'b1, 5'd4, 64'h22);
        step();
        check("drain.idle", 64'(bus.RegWrite), 64'd0);
        check("drain.count", 64'(dut.w_count), 64'd0);

        // A long-latency x0 result is consumed without occupying a slot.
        bus.lu_valid = 1'b1; bus.lu_wa = 5'd0; bus.lu_wd = 64'hEE;
        step();
        bus.lu_valid = 1'b0;
        check("lu_x0.count", 64'(dut.w_count), 64'd0);
        step();
        check("lu_x0.RegWrite", 64'(bus.RegWrite), 64'd0);

        // Starvation: one buffered entry, ALU valid every cycle.
        bus.lu_valid = 1'b1; bus.lu_wa = 5'd10; bus.lu_wd = 64'hAA;
        step();
        bus.lu_valid = 1'b0;
        bus.alu_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            bus.alu_wa = 5'(10 + k); bus.alu_wd = 64'(8'hB0 + k);
            settle();
            check($sformatf("starve.c%0d.stall", k), 64'(bus.stall_alu), 64'd0);
            step();
            check_wr($sformatf("starve.c%0d", k), 1'b1, 5'(10 + k), 64'(8'hB0 + k));
        end
        bus.alu_wa = 5'd15; bus.alu_wd = 64'hB5;
        settle();
        check("starve.c5.stall", 64'(bus.stall_alu), 64'd1);
        step();
        check_wr("starve.fifo_r10", 1'b1, 5'd10, 64'hAA);
        settle();
        check("starve.c6.stall", 64'(bus.stall_alu), 64'd0);
        step();
        check_wr("starve.held_r15", 1'b1, 5'd15, 64'hB5);
        bus.alu_valid = 1'b0;
        step();
        check("starve.idle", 64'(bus.RegWrite), 64'd0);

        // Simultaneous push and pop at count 1.
        bus.lu_valid = 1'b1; bus.lu_wa = 5'd12; bus.lu_wd = 64'hC1;
        step();
        check("pp.count1", 64'(dut.w_count), 64'd1);
        bus.lu_wa = 5'd13; bus.lu_wd = 64'hC2;
        settle();
        check("pp.ready", 64'(bus.lu_ready), 64'd1);
        step();
        bus.lu_valid = 1'b0;
        check_wr("pp.r12", 1'b1, 5'd12, 64'hC1);
        check("pp.count_hold", 64'(dut.w_count), 64'd1);
        step();
        check_wr("pp.r13", 1'b1, 5'd13, 64'hC2);
        step();
        check("pp.idle", 64'(bus.RegWrite), 64'd0);

        // Reset mid-operation with two buffered entries.
        bus.alu_valid = 1'b1; bus.alu_wa = 5'd20; bus.alu_wd = 64'h20;
        bus.lu_valid = 1'b1; bus.lu_wa = 5'd21; bus.lu_wd = 64'hD1;
        step();
        bus.lu_wa = 5'd22; bus.lu_wd = 64'hD2;
        step();
        check("mid.count2", 64'(dut.w_count), 64'd2);
        reset_n = 1'b0; bus.alu_valid = 1'b0; bus.lu_valid = 1'b0;
        step();
        check("mid.rst.RegWrite", 64'(bus.RegWrite), 64'd0);
        check("mid.rst.count", 64'(dut.w_count), 64'd0);
        reset_n = 1'b1;
        step();
        check("mid.post1.RegWrite", 64'(bus.RegWrite), 64'd0);
        step();
        check("mid.post2.RegWrite", 64'(bus.RegWrite), 64'd0);
        check("mid.post2.count", 64'(dut.w_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the execute/memory pipeline and the integer register file write port. It merges single-cycle ALU results with results from long-latency units such as mul/div and load-miss, which arrive through a valid/ready handshake and are held in a small FIFO. The block drives the register file's single write port (`RegWrite`/`wa`/`wd`) with registered outputs. A starvation counter briefly stalls the ALU pipeline so that buffered long-latency results always drain.

## Interface
- `DATA_WIDTH`, 64: register data width.
- `ADDRESS_WIDTH`, 5: register address width.
- `FIFO_DEPTH`, 2: long-latency result buffer entries (≥1).
- `STARVE_LIMIT`, 4: consecutive ALU-won cycles with the FIFO non-empty before `stall_alu` is asserted (≥1).

Ports:
- `clk` in 1: single clock, posedge.
- `reset_n` in 1: synchronous, active-low reset.
- `alu_valid` in 1: ALU result present this cycle.
- `alu_wa` in ADDRESS_WIDTH: ALU destination register.
- `alu_wd` in DATA_WIDTH: ALU result.
- `lu_valid` in 1: long-latency result offered.
- `lu_ready` out 1: FIFO can accept.
- `lu_wa` in ADDRESS_WIDTH: long-latency destination.
- `lu_wd` in DATA_WIDTH: long-latency result.
- `stall_alu` out 1: upstream must hold its ALU result this cycle.
- `RegWrite` out 1: register file write enable.
- `wa` out ADDRESS_WIDTH: register file write address.
- `wd` out DATA_WIDTH: register file write data.

## Operation
- **Enqueue.**
  - A long-latency result is accepted on `lu_valid && lu_ready`.
  - `lu_ready = reset_n && (count < FIFO_DEPTH)`. Readiness is computed from the registered `count`; a pop in the same cycle does not free space for a push.
  - An accepted result with `lu_wa == 0` is consumed but not stored.
- **Selection, evaluated each cycle:**
  1. If `alu_valid && !stall_alu`: the ALU result is selected.
  2. Else if `count > 0`: the FIFO head is popped and selected.
  3. Else: nothing is selected.
- **ALU hold.**
  - While `stall_alu` is high, `alu_valid` is ignored; upstream holds its result and re-presents it the next cycle.
  - The block never drops an ALU result.
- **x0 suppression.** If the selected entry has address 0, the next-cycle `RegWrite` is 0. The entry still counts as consumed.
- **Ordering.**
  - FIFO order is preserved within the long-latency stream.
  - Ordering across the ALU and long-latency streams is the arrival order at this block. Upstream scoreboarding prevents write-after-write conflicts.
- **Starvation counter `starve_cnt`** (0..STARVE_LIMIT):
  - Increments when `count > 0` and the ALU is selected.
  - Clears on any FIFO pop or when `count == 0`.
  - `stall_alu = (starve_cnt == STARVE_LIMIT)`. In that cycle the FIFO pops and the counter clears, so `stall_alu` is a one-cycle pulse.
- **Simultaneous push and pop** when `0 < count < FIFO_DEPTH`: `count` is unchanged, the head advances and the new entry is written at the tail.

## Timing
- **Reset** (`reset_n` low at posedge):
  - `RegWrite`=0, `wa`=0, `wd`=0.
  - `count`=0, FIFO pointers 0, `starve_cnt`=0.
  - `stall_alu`=0 and `lu_ready`=0 while `reset_n` is low.
- **Reset mid-operation:** buffered FIFO entries are discarded and no write issues in the following cycle.
- **Latency:**
  - ALU result: 1 cycle; input at edge N appears on `RegWrite`/`wa`/`wd` after edge N+1.
  - Long-latency result into an empty FIFO with the ALU idle: 2 cycles (enqueue, then pop). There is no enqueue-to-output bypass.
- **Outputs:** `RegWrite`, `wa` and `wd` are registered and stable for a full cycle. The register file commits them on the negedge inside that cycle.
- **Throughput:** at most one register file write per cycle.
- **Pointer wrap:** read and write pointers wrap modulo `FIFO_DEPTH`, and `count` disambiguates full from empty. Non-power-of-two depths must work.

## Structure
- Shared package `riscv_pkg` holds:
  - `DATA_WIDTH` and `ADDRESS_WIDTH` constants;
  - the `wb_req_t` struct `{wa, wd}`, used for the FIFO entry and the selected request.
- Sub-module `wb_fifo`: a synchronous FIFO of `wb_req_t`, parameterised by `FIFO_DEPTH`, exposing push, pop, head, `count`, full and empty. It uses the same `clk`/`reset_n`.
- The `wb_arbiter` top level contains the selection logic, the starvation counter and the output registers.

## Test plan
- **Reset:** hold `reset_n`=0 for 3 cycles with `alu_valid`=1 → `RegWrite`=0, `wa`=0, `wd`=0, `lu_ready`=0. After release, `lu_ready`=1.
- **ALU path and x0:**
  - `alu_wa`=5, `alu_wd`=0xDEAD → next cycle `RegWrite`=1, `wa`=5, `wd`=0xDEAD.
  - `alu_wa`=0 → `RegWrite`=0.
- **FIFO fill:**
  - Push LU results (3,0x11) and (4,0x22) while the ALU is busy, then offer a third → `lu_ready`=0 and the third is not accepted.
  - ALU idle → writes to regs 3 then 4, in order.
- **Starvation:**
  - With FIFO `count`=1 and `alu_valid` held high → `stall_alu` pulses high on the 5th cycle.
  - The FIFO entry is written the next cycle; the held ALU result follows one cycle later.
- **Simultaneous push and pop at `count`=1:** `count` stays 1 and entries are written in FIFO order.
- **Reset mid-operation:** FIFO `count`=2, then assert `reset_n`=0 for 1 cycle → no later writes of the buffered entries and `count`=0.
